cpu_pipe_control: RTL and testbench
===================================

Name: cpu_pipe_control

Overview:
- Pipelined successor to the single-cycle control decoder.
- Decodes the 4-bit opcode in the ID stage and registers the full control bundle into the ID/EX control register.
- Detects load-use hazards and generates a stall; inserts bubbles on stall or flush.
- Sequences HLT through a drain state machine, then halts the core.

Parameters:
- OPC_W, 4, opcode width; only values 0..15 are decoded, upper bits must be 0 otherwise the default (bubble) bundle is used.
- REG_W, 4, register-address width.
- DRAIN_CYCLES, 3, cycles after HLT enters EX before halted asserts (pipeline depth behind EX); legal range 1..15.
- ZERO_REG, 1, 1 = register 0 is hardwired zero and never causes a hazard.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_opcode  in  OPC_W  opcode of the ID instruction.
- id_rs  in  REG_W  source register 1.
- id_rt  in  REG_W  source register 2.
- id_rd  in  REG_W  destination register.
- flush  in  1  taken branch resolved; kill the ID instruction.
- stall  out  1  combinational; hold PC and IF/ID this cycle.
- pc_hold  out  1  registered; 1 in DRAIN/HALTED.
- halted  out  1  registered; 1 only in HALTED.
- ex_valid  out  1  ID/EX register holds a real instruction.
- ex_rd  out  REG_W  registered destination register.
- ex_reg_read, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_write, ex_lh, ex_hlt  out  1 each  registered controls.
- ex_alu_op  out  3  registered ALU operation.
- ex_mem_to_reg  out  2  registered writeback select: 00 PC+2, 01 immediate, 10 ALU, 11 memory.
- ex_pc_src  out  2  registered PC select.

Behaviour:
- Reset (async): all ex_* = 0, stall = 0, pc_hold = 0, halted = 0, state = RUN, drain counter = 0.
- Decode table (opcode: controls set to 1 / alu_op / mem_to_reg / pc_src; unlisted controls 0):
  - 0000 ADD, 0001 SUB, 0010 XOR, 0011 RED, 0111 PADDSB: reg_read, reg_write / 000,001,010,011,111 / 10 / 00.
  - 0100 SLL, 0101 SRA, 0110 ROR: reg_read, alu_src, reg_write / 100,101,110 / 10 / 00.
  - 1000 LW: reg_read, mem_read, alu_src, reg_write / 000 / 11 / 00.
  - 1001 SW: reg_read, mem_write, alu_src / 000 / 00 / 00.
  - 1010 LLB: reg_write / 000 / 01 / 00.
  - 1011 LHB: reg_write, lh / 000 / 01 / 00.
  - 1100 B: none / 000 / 00 / 11.
  - 1101 BR: reg_read / 000 / 00 / 01.
  - 1110 PCS: reg_write / 000 / 00 / 00.
  - 1111 HLT: hlt / 000 / 00 / 00.
- rt-users are opcodes 0000–0011, 0111 and 1001; rs-users are opcodes with reg_read = 1.
- Hazard (combinational), asserted when all of the following hold:
  - state = RUN, id_valid, !flush, ex_valid, ex_mem_read;
  - (ex_rd == id_rs and the ID instruction is an rs-user) or (ex_rd == id_rt and it is an rt-user);
  - and not (ZERO_REG and ex_rd == 0).
- stall = hazard.
- Per-cycle update of the ID/EX register (priority high to low):
  1. rst;
  2. flush or stall or !id_valid or state != RUN → bubble (ex_valid = 0, all controls 0, ex_rd = 0);
  3. otherwise load the decoded bundle and id_rd, and set ex_valid = 1.
  - Latency ID→EX = 1 cycle.
- A stall lasts exactly 1 cycle per load-use pair (the LW leaves EX).
- FSM:
  - RUN → DRAIN when an HLT is accepted into ID/EX (rule 3); pc_hold goes high the same edge; counter loads DRAIN_CYCLES.
  - DRAIN: ID inputs are ignored (bubbles); counter decrements each cycle.
    - flush → RUN: counter cleared, pc_hold = 0 next cycle (an older branch killed the HLT); flush has priority over the count.
    - counter reaches 1 without flush → HALTED next edge.
  - HALTED: halted = 1, pc_hold = 1; flush and all inputs are ignored; only rst exits.
- Simultaneous flush and HLT in ID: flush wins and the FSM stays in RUN.

Test Plan:
- Reset mid-DRAIN (counter = 2) → all outputs 0 immediately, without a clock edge; state = RUN.
- ADD (0000) rd = 3, then SLL (0100) → next cycles ex_alu_op = 000 then 100 with ex_alu_src 0 then 1; ex_mem_to_reg = 10; ex_reg_write = 1; no stall.
- LW rd = 5 in EX, ID = SUB rs = 5 → stall = 1 for 1 cycle, bubble in EX, then SUB loads; repeat with rd = 0 and ZERO_REG = 1 → no stall; SW with rt = 5 → stall; LLB using rd = 5 → no stall.
- flush with valid ADD in ID while a hazard is present → stall = 0, ex_valid = 0 next cycle.
- HLT accepted, DRAIN_CYCLES = 3 → pc_hold = 1 at the next edge, halted = 1 exactly 3 cycles later; later inputs and flush have no effect.
- HLT accepted, flush in the first DRAIN cycle → state returns to RUN, pc_hold = 0, halted never asserts.

Source files
------------

// File: rtl/cpu_pipe_control.sv
// ID-stage control for the pipelined core: opcode decode into the ID/EX
// control register, load-use hazard detection, bubble insertion on
// stall/flush, and the HLT drain/halt sequencer.
//
// Handshake note: the ID/EX register accepts the ID instruction on a rising
// edge only when id_valid=1, flush=0, stall=0 and the sequencer is in RUN;
// in every other cycle it loads a bubble. While stall=1 the upstream stages
// must hold PC and IF/ID so the same instruction is presented again.
module cpu_pipe_control #(
  parameter int OPC_W        = 4,
  parameter int REG_W        = 4,
  parameter int DRAIN_CYCLES = 3,
  parameter int ZERO_REG     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [OPC_W-1:0] id_opcode,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             flush,
  output logic             stall,
  output logic             pc_hold,
  output logic             halted,
  output logic             ex_valid,
  output logic [REG_W-1:0] ex_rd,
  output logic             ex_reg_read,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_alu_src,
  output logic             ex_reg_write,
  output logic             ex_lh,
  output logic             ex_hlt,
  output logic [2:0]       ex_alu_op,
  output logic [1:0]       ex_mem_to_reg,
  output logic [1:0]       ex_pc_src,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic       reg_read;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       lh;
    logic       hlt;
    logic [2:0] alu_op;
    logic [1:0] mem_to_reg;
    logic [1:0] pc_src;
  } ctl_t;

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  ctl_t       dec, ex_ctl;
  logic       rt_user;
  logic       opc_ok;
  logic [3:0] op4;
  logic [31:0] opc_ext;
  logic       hazard;
  logic       id_accept;

  assign opc_ext = 32'(id_opcode);
  assign opc_ok  = (opc_ext < 32'd16);
  assign op4     = opc_ext[3:0];

  // Opcode decode; out-of-range opcodes decode to the all-zero bundle.
  always_comb begin
    dec     = '0;
    rt_user = 1'b0;
    if (opc_ok) begin
      case (op4)
        4'h0, 4'h1, 4'h2, 4'h3, 4'h7: begin
          dec.reg_read   = 1'b1;
          dec.reg_write  = 1'b1;
          dec.alu_op     = op4[2:0];
          dec.mem_to_reg = 2'b10;
          rt_user        = 1'b1;
        end
        4'h4, 4'h5, 4'h6: begin
          dec.reg_read   = 1'b1;
          dec.alu_src    = 1'b1;
          dec.reg_write  = 1'b1;
          dec.alu_op     = op4[2:0];
          dec.mem_to_reg = 2'b10;
        end
        4'h8: begin
          dec.reg_read   = 1'b1;
          dec.mem_read   = 1'b1;
          dec.alu_src    = 1'b1;
          dec.reg_write  = 1'b1;
          dec.mem_to_reg = 2'b11;
        end
        4'h9: begin
          dec.reg_read  = 1'b1;
          dec.mem_write = 1'b1;
          dec.alu_src   = 1'b1;
          rt_user       = 1'b1;
        end
        4'hA: begin
          dec.reg_write  = 1'b1;
          dec.mem_to_reg = 2'b01;
        end
        4'hB: begin
          dec.reg_write  = 1'b1;
          dec.lh         = 1'b1;
          dec.mem_to_reg = 2'b01;
        end
        4'hC: dec.pc_src = 2'b11;
        4'hD: begin
          dec.reg_read = 1'b1;
          dec.pc_src   = 2'b01;
        end
        4'hE: dec.reg_write = 1'b1;
        default: dec.hlt = 1'b1;
      endcase
    end
  end

  // Load-use hazard: a load in EX whose destination feeds the ID instruction.
  always_comb begin
    hazard = 1'b0;
    if (state == S_RUN && id_valid && !flush && ex_valid && ex_ctl.mem_read) begin
      if ((ex_rd == id_rs && dec.reg_read) || (ex_rd == id_rt && rt_user))
        hazard = 1'b1;
      if ((ZERO_REG != 0) && (ex_rd == '0))
        hazard = 1'b0;
    end
  end

  assign stall     = hazard;
  assign id_accept = (state == S_RUN) && id_valid && !flush && !hazard && opc_ok;

  // ID/EX control register: accepted instruction or bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_rd    <= '0;
      ex_ctl   <= '0;
    end else if (id_accept) begin
      ex_valid <= 1'b1;
      ex_rd    <= id_rd;
      ex_ctl   <= dec;
    end else begin
      ex_valid <= 1'b0;
      ex_rd    <= '0;
      ex_ctl   <= '0;
    end
  end

  assign ex_reg_read   = ex_ctl.reg_read;
  assign ex_mem_read   = ex_ctl.mem_read;
  assign ex_mem_write  = ex_ctl.mem_write;
  assign ex_alu_src    = ex_ctl.alu_src;
  assign ex_reg_write  = ex_ctl.reg_write;
  assign ex_lh         = ex_ctl.lh;
  assign ex_hlt        = ex_ctl.hlt;
  assign ex_alu_op     = ex_ctl.alu_op;
  assign ex_mem_to_reg = ex_ctl.mem_to_reg;
  assign ex_pc_src     = ex_ctl.pc_src;

  // Sequencer next state: HLT drains the pipe behind EX, an older flush aborts it.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_RUN: begin
        if (id_accept && dec.hlt) begin
          state_nx = S_DRAIN;
          cnt_nx   = 4'(DRAIN_CYCLES);
        end
      end
      S_DRAIN: begin
        if (flush) begin
          state_nx = S_RUN;
          cnt_nx   = 4'd0;
        end else if (cnt <= 4'd1) begin
          state_nx = S_HALTED;
          cnt_nx   = 4'd0;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      S_HALTED: begin
        state_nx = S_HALTED;
        cnt_nx   = 4'd0;
      end
      default: begin
        state_nx = S_RUN;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  // Sequencer registers; pc_hold/halted are flopped from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_RUN;
      cnt     <= 4'd0;
      pc_hold <= 1'b0;
      halted  <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      pc_hold <= (state_nx != S_RUN);
      halted  <= (state_nx == S_HALTED);
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_cpu_pipe_control.sv
// Bench for cpu_pipe_control: directed scenarios followed by random traffic,
// all outputs compared against a behavioural model of the control rules.
module tb_cpu_pipe_control;

  localparam int DC = 3;
  localparam int W  = 19;

  // Clock / reset
  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, flush;
  logic [3:0] id_opcode, id_rs, id_rt, id_rd;
  logic       stall, pc_hold, halted, ex_valid;
  logic [3:0] ex_rd;
  logic       ex_reg_read, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_write, ex_lh, ex_hlt;
  logic [2:0] ex_alu_op;
  logic [1:0] ex_mem_to_reg, ex_pc_src, state_dbg;

  always #5 clk = ~clk;

  cpu_pipe_control #(.OPC_W(4), .REG_W(4), .DRAIN_CYCLES(DC), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
    .stall(stall), .pc_hold(pc_hold), .halted(halted), .ex_valid(ex_valid),
    .ex_rd(ex_rd), .ex_reg_read(ex_reg_read), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
    .ex_lh(ex_lh), .ex_hlt(ex_hlt), .ex_alu_op(ex_alu_op),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_pc_src(ex_pc_src), .state_dbg(state_dbg)
  );

  // Scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // Reference model state: mode 0 run, 1 draining, 2 halted
  logic [W-1:0] m_ex;
  int m_mode;
  int m_age;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Control bundle {rr,mr,mw,as,rw,lh,hlt,alu_op[3],m2r[2],pc_src[2]} from the opcode table
  function automatic logic [13:0] ref_ctl(input logic [3:0] op);
    logic rr, mr, mw, as, rw, lh, h;
    logic [2:0] ao;
    logic [1:0] m2r, ps;
    {rr, mr, mw, as, rw, lh, h} = 7'd0;
    ao = 3'd0; m2r = 2'd0; ps = 2'd0;
    if (op <= 4'd7) begin
      rr = 1; rw = 1; ao = op[2:0]; m2r = 2'b10;
      as = (op >= 4'd4 && op <= 4'd6);
    end else begin
      case (op)
        4'd8:  begin rr = 1; mr = 1; as = 1; rw = 1; m2r = 2'b11; end
        4'd9:  begin rr = 1; mw = 1; as = 1; end
        4'd10: begin rw = 1; m2r = 2'b01; end
        4'd11: begin rw = 1; lh = 1; m2r = 2'b01; end
        4'd12: ps = 2'b11;
        4'd13: begin rr = 1; ps = 2'b01; end
        4'd14: rw = 1;
        default: h = 1;
      endcase
    end
    return {rr, mr, mw, as, rw, lh, h, ao, m2r, ps};
  endfunction

  function automatic logic rt_user(input logic [3:0] op);
    return (op <= 4'd3) || (op == 4'd7) || (op == 4'd9);
  endfunction

  function automatic logic [W-1:0] dut_bundle();
    return {ex_valid, ex_rd, ex_reg_read, ex_mem_read, ex_mem_write, ex_alu_src,
            ex_reg_write, ex_lh, ex_hlt, ex_alu_op, ex_mem_to_reg, ex_pc_src};
  endfunction

  // Async reset applied mid-cycle; outputs must clear without a clock edge
  task automatic apply_reset();
    #2;
    rst = 1'b1; id_valid = 1'b0; flush = 1'b0;
    #1;
    check("rst_stall", stall, 0);
    check("rst_bundle", dut_bundle(), 0);
    check("rst_pc_hold", pc_hold, 0);
    check("rst_halted", halted, 0);
    check("rst_state", state_dbg, 0);
    m_ex = '0; m_mode = 0; m_age = 0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Driver: one ID-stage cycle, stall checked before the edge, registers after
  task automatic step(input logic v, input logic [3:0] op, input logic [3:0] rs,
                      input logic [3:0] rt, input logic [3:0] rd, input logic fl);
    logic [13:0] ctl;
    logic hz, acc;
    logic [3:0] erd;
    @(negedge clk);
    id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd; flush = fl;
    #1;
    ctl = ref_ctl(op);
    erd = m_ex[17:14];
    hz = (m_mode == 0) && v && !fl && m_ex[18] && m_ex[12] && (erd != 4'd0) &&
         ((erd == rs && ctl[13]) || (erd == rt && rt_user(op)));
    check("stall", stall, hz);
    acc = (m_mode == 0) && v && !fl && !hz;
    if (m_mode == 0) begin
      if (acc && op == 4'd15) begin m_mode = 1; m_age = 0; end
    end else if (m_mode == 1) begin
      if (fl) m_mode = 0;
      else begin
        m_age++;
        if (m_age == DC) m_mode = 2;
      end
    end
    m_ex = acc ? {1'b1, rd, ctl} : '0;
    exp_q.push_back(m_ex);
    @(posedge clk);
    #1;
    check("ex_bundle", dut_bundle(), exp_q.pop_front());
    check("pc_hold", pc_hold, m_mode != 0);
    check("halted", halted, m_mode == 2);
    check("state", state_dbg, m_mode);
  endtask

  initial begin
    rst = 1'b1; id_valid = 0; flush = 0; id_opcode = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    apply_reset();

    // ALU register op then shift-immediate
    step(1, 4'd0, 4'd1, 4'd2, 4'd3, 0);
    check("add_alu_src", ex_alu_src, 0);
    step(1, 4'd4, 4'd3, 4'd0, 4'd4, 0);
    check("sll_alu_op", ex_alu_op, 3'b100);
    check("sll_alu_src", ex_alu_src, 1);

    // Load-use: SUB on rs, then r0 load, SW on rt, LLB
    step(1, 4'd8, 4'd1, 4'd0, 4'd5, 0);
    step(1, 4'd1, 4'd5, 4'd2, 4'd6, 0);
    check("lu_bubble", ex_valid, 0);
    step(1, 4'd1, 4'd5, 4'd2, 4'd6, 0);
    check("lu_sub_loaded", ex_valid, 1);
    step(1, 4'd8, 4'd1, 4'd0, 4'd0, 0);
    step(1, 4'd1, 4'd0, 4'd0, 4'd6, 0);
    step(1, 4'd8, 4'd1, 4'd0, 4'd5, 0);
    step(1, 4'd9, 4'd1, 4'd5, 4'd0, 0);
    step(1, 4'd9, 4'd1, 4'd5, 4'd0, 0);
    step(1, 4'd8, 4'd1, 4'd0, 4'd5, 0);
    step(1, 4'd10, 4'd5, 4'd5, 4'd5, 0);

    // Flush beats a pending hazard
    step(1, 4'd8, 4'd1, 4'd0, 4'd5, 0);
    step(1, 4'd0, 4'd5, 4'd5, 4'd7, 1);
    check("flush_bubble", ex_valid, 0);

    // HLT drains then halts; later traffic and flush ignored
    step(1, 4'd15, 4'd0, 4'd0, 4'd0, 0);
    check("hlt_pc_hold", pc_hold, 1);
    step(1, 4'd0, 4'd1, 4'd2, 4'd3, 0);
    step(1, 4'd0, 4'd1, 4'd2, 4'd3, 0);
    check("hlt_not_yet", halted, 0);
    step(1, 4'd0, 4'd1, 4'd2, 4'd3, 0);
    check("hlt_halted", halted, 1);
    for (int i = 0; i < 4; i++) step(1, 4'd0, 4'd1, 4'd2, 4'd3, 1);
    apply_reset();

    // Flush in first drain cycle aborts the halt
    step(1, 4'd15, 4'd0, 4'd0, 4'd0, 0);
    step(1, 4'd0, 4'd1, 4'd2, 4'd3, 1);
    check("abort_pc_hold", pc_hold, 0);
    for (int i = 0; i < 5; i++) step(1, 4'd2, 4'd1, 4'd2, 4'd3, 0);

    // Flush together with HLT in ID: HLT is killed
    step(1, 4'd15, 4'd0, 4'd0, 4'd0, 1);
    check("flush_hlt_state", state_dbg, 0);

    // Reset in the middle of a drain
    step(1, 4'd15, 4'd0, 4'd0, 4'd0, 0);
    step(1, 4'd0, 4'd1, 4'd2, 4'd3, 0);
    apply_reset();

    // Random traffic with clustered register numbers to provoke hazards
    for (int i = 0; i < 800; i++) begin
      if (m_mode == 2 && $urandom_range(0, 3) == 0) apply_reset();
      else step($urandom_range(0, 7) != 0, 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)),
                4'($urandom_range(0, 5)), $urandom_range(0, 7) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
